// File: rtl/synth_pkg.sv
// synth_pkg: widths and state encoding shared by the tone generator and period selector
package synth_pkg;
  localparam int HALF_PERIOD_W = 8;
  localparam int SAMPLE_W = 8;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..DIV-1 prescaler, held at zero while clear is high
module tick_divider #(
  parameter int DIV = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || clear) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/square_wave_gen.sv
// square_wave_gen: glitch-free square-wave tone FSM; the period only reloads at half-period boundaries
module square_wave_gen
  import synth_pkg::*;
#(
  parameter int DIV = 64,
  parameter logic signed [SAMPLE_W-1:0] AMP = 8'sd100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [HALF_PERIOD_W-1:0]   halfPeriod,
  output logic                       wave,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       active,
  output logic                       toggle
);
  state_t r_state;
  logic [HALF_PERIOD_W-1:0] r_period;
  logic [HALF_PERIOD_W-1:0] r_cnt;
  logic w_tick;
  logic w_clear;
  logic w_step;
  logic w_bound;
  assign w_clear = r_state == IDLE;
  assign w_step  = r_state == RUN && w_tick;
  assign w_bound = w_step && r_cnt == r_period - 1'b1;
  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_cnt    <= '0;
      wave     <= 1'b0;
      sample   <= '0;
      active   <= 1'b0;
      toggle   <= 1'b0;
    end else begin
      toggle <= 1'b0;
      if (r_state == IDLE) begin
        if (halfPeriod != '0) begin
          r_state  <= RUN;
          r_period <= halfPeriod;
          r_cnt    <= '0;
          wave     <= 1'b1;
          sample   <= AMP;
          active   <= 1'b1;
          toggle   <= 1'b1;
        end
      end else if (w_bound) begin
        r_cnt <= '0;
        if (halfPeriod != '0) begin
          r_period <= halfPeriod;
          wave     <= !wave;
          sample   <= wave ? -AMP : AMP;
          toggle   <= 1'b1;
        end else begin
          r_state  <= IDLE;
          r_period <= '0;
          wave     <= 1'b0;
          sample   <= '0;
          active   <= 1'b0;
          toggle   <= wave;
        end
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/square_wave_gen.md
SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

Interface
- REQ-001: Parameter DIV, default 64: clock cycles per half-period count step, legal range 1..256.
- REQ-002: Parameter AMP, default 8'sd100: signed sample magnitude, legal range 1..127.
- REQ-003: clk  input  1: single clock for all logic.
- REQ-004: rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-005: halfPeriod  input  8: half-period in count steps, driven by the upstream period selector; 0 means no key pressed.
- REQ-006: wave  output  1: square-wave output.
- REQ-007: sample  output  8: signed sample; +AMP while wave=1 in RUN, -AMP while wave=0 in RUN, 0 in IDLE.
- REQ-008: active  output  1: 1 exactly while the state is RUN.
- REQ-009: toggle  output  1: one-cycle pulse in the cycle after each wave transition, including the entry into RUN and the return to IDLE.

Function
- REQ-010: The block SHALL be a two-state FSM: IDLE and RUN.
- REQ-011: In IDLE, wave, sample, the step counter and the prescaler SHALL be 0.
- REQ-012: In IDLE, halfPeriod != 0 sampled at edge N SHALL produce the following after edge N: state RUN, period_q = halfPeriod, cnt = 0, prescaler = 0, wave = 1, toggle = 1.
- REQ-013: In RUN, the prescaler SHALL count 0..DIV-1 and wrap; the step enable is asserted when the prescaler equals DIV-1.
- REQ-014: On a step, cnt SHALL increment; on a step with cnt == period_q-1 (a half-period boundary), cnt SHALL reset to 0.
- REQ-015: Each half-period SHALL last exactly period_q × DIV clk cycles.
- REQ-016: At a boundary with halfPeriod != 0, wave SHALL invert and period_q SHALL reload from halfPeriod, so a period change never cuts a half-cycle short (glitch-free).
- REQ-017: At a boundary with halfPeriod == 0, the block SHALL go to IDLE with wave = 0 and sample = 0, and toggle SHALL pulse only if wave was 1.
- REQ-018: halfPeriod changes between boundaries, including transient 0, SHALL be ignored.
- REQ-019: halfPeriod SHALL NOT be registered beyond period_q, so the IDLE-to-RUN latency is one clk cycle.
- REQ-020: period_q == 1 with DIV == 1 SHALL toggle wave on every clk cycle.
- REQ-021: cnt and the prescaler SHALL be wide enough that they never overflow: 8 bits for cnt and clog2(DIV) bits for the prescaler, minimum 1.
- REQ-022: All outputs SHALL be registered.

Reset
- REQ-023: When rst = 1, the following edge SHALL set state IDLE, wave 0, sample 0, active 0, toggle 0, period_q 0, cnt 0, prescaler 0.
- REQ-024: rst SHALL take priority over all other inputs, including mid-half-period in RUN.
- REQ-025: After rst falls, the block SHALL behave as freshly idle; a nonzero halfPeriod on the first non-reset edge SHALL start RUN per REQ-012.

Structure
- REQ-026: Package synth_pkg SHALL hold HALF_PERIOD_W = 8, SAMPLE_W = 8 and the state enum typedef (IDLE, RUN), shared with the period selector.
- REQ-027: The prescaler SHALL be a sub-module, tick_divider (clk, rst, clear, tick), with parameter DIV.
- REQ-028: The FSM, counter and output registers SHALL reside in square_wave_gen.

Verification (DIV=2, AMP=100 unless stated)
- REQ-029: Reset held 3 cycles with halfPeriod=5 -> wave=0, sample=0, active=0 throughout; after release, RUN starts on the next edge.
- REQ-030: halfPeriod=3 constant -> wave high 6 cycles, low 6 cycles, repeating; sample alternates +100/-100; one toggle pulse per transition.
- REQ-031: halfPeriod changes 3->5 mid half-cycle -> current half-cycle stays 6 cycles; subsequent half-cycles are 10 cycles.
- REQ-032: halfPeriod drops to 0 mid half-cycle -> wave holds until the boundary, then wave=0, active=0, sample=0; a 1-cycle 0 glitch in the middle of a half-cycle has no effect.
- REQ-033: DIV=1, halfPeriod=1 -> wave toggles every cycle, toggle stays high continuously.
- REQ-034: rst asserted mid-RUN (cnt=2) -> all outputs 0 on the next edge; when halfPeriod=4 is held, restart gives a first half-period of 8 cycles.
